// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : Power-up / reset / lock-retry sequencer for a single PLLE2_BASE.
//            Optional macro PLL_SEQ_AUTO_RELOCK_EN: lock loss in READY retries
//            instead of faulting.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int PWRUP_CYCLES  = 4,
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       enable,
  input  logic       locked_in,
  output logic       pll_pwrdwn,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retries,
  output logic [2:0] state
);

  localparam logic [2:0] c_ST_OFF       = 3'd0;
  localparam logic [2:0] c_ST_PWRUP     = 3'd1;
  localparam logic [2:0] c_ST_RST_HOLD  = 3'd2;
  localparam logic [2:0] c_ST_WAIT_LOCK = 3'd3;
  localparam logic [2:0] c_ST_SETTLE    = 3'd4;
  localparam logic [2:0] c_ST_READY     = 3'd5;
  localparam logic [2:0] c_ST_FAULT     = 3'd6;

  localparam logic [CNT_WIDTH-1:0] c_PWRUP_LAST   = CNT_WIDTH'(PWRUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [3:0]           c_MAX_RETRIES  = 4'(MAX_RETRIES);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
  logic [3:0]           retries_q, retries_d;
  logic                 sync1_q, locked_s_q;
  logic                 pwrdwn_q, pwrdwn_d;
  logic                 rst_q, rst_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;

  logic                 w_timeout;
  logic [2:0]           w_retry_state;
  logic [3:0]           w_retry_cnt;

  // State register, counters, LOCKED synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= c_ST_OFF;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      scnt_q     <= '0;
      retries_q  <= 4'd0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      pwrdwn_q   <= 1'b1;
      rst_q      <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      scnt_q     <= scnt_d;
      retries_q  <= retries_d;
      sync1_q    <= locked_in;
      locked_s_q <= sync1_q;
      pwrdwn_q   <= pwrdwn_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  // >= rather than == so a timeout still fires after SETTLE falls back to
  // WAIT_LOCK with tcnt already saturated at the limit.
  assign w_timeout     = (tcnt_q >= c_TIMEOUT_LAST);
  assign w_retry_state = (retries_q < c_MAX_RETRIES) ? c_ST_RST_HOLD : c_ST_FAULT;
  assign w_retry_cnt   = (retries_q < c_MAX_RETRIES) ? retries_q + 4'd1 : retries_q;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    tcnt_d    = tcnt_q;
    scnt_d    = scnt_q;
    retries_d = retries_q;
    if (!enable) begin
      state_d = c_ST_OFF;
    end else begin
      case (state_q)
        c_ST_OFF: begin
          retries_d = 4'd0;
          pcnt_d    = '0;
          state_d   = c_ST_PWRUP;
        end
        c_ST_PWRUP: begin
          if (pcnt_q == c_PWRUP_LAST) begin
            pcnt_d  = '0;
            state_d = c_ST_RST_HOLD;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        c_ST_RST_HOLD: begin
          if (pcnt_q == c_RST_LAST) begin
            tcnt_d  = '0;
            state_d = c_ST_WAIT_LOCK;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        c_ST_WAIT_LOCK: begin
          if (!w_timeout) tcnt_d = tcnt_q + 1'b1;
          if (locked_s_q) begin
            scnt_d  = '0;
            state_d = c_ST_SETTLE;
          end else if (w_timeout) begin
            pcnt_d    = '0;
            retries_d = w_retry_cnt;
            state_d   = w_retry_state;
          end
        end
        c_ST_SETTLE: begin
          if (!w_timeout) tcnt_d = tcnt_q + 1'b1;
          if (!locked_s_q) begin
            state_d = c_ST_WAIT_LOCK;
          end else if (scnt_q == c_SETTLE_LAST) begin
            state_d = c_ST_READY;
          end else if (w_timeout) begin
            pcnt_d    = '0;
            retries_d = w_retry_cnt;
            state_d   = w_retry_state;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        c_ST_READY: begin
          if (!locked_s_q) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            pcnt_d    = '0;
            retries_d = w_retry_cnt;
            state_d   = w_retry_state;
`else
            state_d   = c_ST_FAULT;
`endif
          end
        end
        c_ST_FAULT: begin
          state_d = c_ST_FAULT;
        end
        default: begin
          state_d = c_ST_OFF;
        end
      endcase
    end
  end

  // Output decode from the next state so registered outputs track state_q
  always_comb begin
    pwrdwn_d = 1'b1;
    rst_d    = 1'b1;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      c_ST_PWRUP, c_ST_RST_HOLD: begin
        pwrdwn_d = 1'b0;
      end
      c_ST_WAIT_LOCK, c_ST_SETTLE: begin
        pwrdwn_d = 1'b0;
        rst_d    = 1'b0;
      end
      c_ST_READY: begin
        pwrdwn_d = 1'b0;
        rst_d    = 1'b0;
        ready_d  = 1'b1;
      end
      c_ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        pwrdwn_d = 1'b1;
      end
    endcase
  end

  assign pll_pwrdwn = pwrdwn_q;
  assign pll_rst    = rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retries    = retries_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Brief    : Scoreboard bench for pll_lock_sequencer (LOCK_TIMEOUT=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

  localparam int LOCK_TIMEOUT = 100;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_PWRUP  = 3'd1;
  localparam logic [2:0] ST_RSTH   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_READY  = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  logic       clk = 1'b0;
  logic       RST;
  logic       enable;
  logic       locked_in;
  logic       pll_pwrdwn;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retries;
  logic [2:0] state;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int          q_cyc[$];
  string       q_name[$];
  logic [10:0] q_val[$];

  pll_lock_sequencer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .enable    (enable),
    .locked_in (locked_in),
    .pll_pwrdwn(pll_pwrdwn),
    .pll_rst   (pll_rst),
    .ready     (ready),
    .fault     (fault),
    .retries   (retries),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pin levels for each state: {pwrdwn, rst, ready, fault, retries, state}
  function automatic logic [10:0] snap(input logic [2:0] st, input logic [3:0] rt);
    logic pd, pr, rd, ft;
    pd = (st == ST_OFF) || (st == ST_FAULT);
    pr = (st == ST_OFF) || (st == ST_PWRUP) || (st == ST_RSTH) || (st == ST_FAULT);
    rd = (st == ST_READY);
    ft = (st == ST_FAULT);
    return {pd, pr, rd, ft, rt, st};
  endfunction

  task automatic expect_at(input int delta, input string name,
                           input logic [2:0] st, input logic [3:0] rt);
    q_cyc.push_back(cyc + delta);
    q_name.push_back(name);
    q_val.push_back(snap(st, rt));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] got;
    got = {pll_pwrdwn, pll_rst, ready, fault, retries, state};
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] <= cyc) begin
        n_cmp++;
        if (q_cyc[i] < cyc || got !== q_val[i]) begin
          n_bad++;
          $display("FAIL %s @cycle %0d: got {pwrdwn,rst,ready,fault,retries,state}=%b want %b",
                   q_name[i], cyc, got, q_val[i]);
        end
        q_cyc.delete(i);
        q_name.delete(i);
        q_val.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending, want 0", q_cyc.size());
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    enable    = 1'b0;
    locked_in = 1'b0;
    tick(3);
    expect_at(0, "reset_state", ST_OFF, 4'd0);
    RST = 1'b0;
    tick(2);
    expect_at(0, "idle_off", ST_OFF, 4'd0);

    // Normal bring-up: lock 50 cycles after pll_rst falls
    enable = 1'b1;
    expect_at(0,  "t1_still_off",    ST_OFF,   4'd0);
    expect_at(1,  "t1_pwrdwn_fall",  ST_PWRUP, 4'd0);
    expect_at(4,  "t1_pwrup_last",   ST_PWRUP, 4'd0);
    expect_at(5,  "t1_rsthold_first", ST_RSTH, 4'd0);
    expect_at(12, "t1_rsthold_last", ST_RSTH,  4'd0);
    expect_at(13, "t1_rst_fall",     ST_WAIT,  4'd0);
    tick(13);
    tick(50);
    locked_in = 1'b1;
    expect_at(2,  "t1_sync_latency", ST_WAIT,   4'd0);
    expect_at(3,  "t1_settle_entry", ST_SETTLE, 4'd0);
    expect_at(18, "t1_pre_ready",    ST_SETTLE, 4'd0);
    expect_at(19, "t1_ready_rise",   ST_READY,  4'd0);
    tick(25);

    // Lock loss in READY
    locked_in = 1'b0;
    expect_at(2, "t4_ready_hold", ST_READY, 4'd0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    expect_at(3,  "t4_relock_rsthold", ST_RSTH, 4'd1);
    expect_at(10, "t4_relock_rst_end", ST_RSTH, 4'd1);
    expect_at(11, "t4_relock_wait",    ST_WAIT, 4'd1);
    tick(11);
    locked_in = 1'b1;
    expect_at(18, "t4_relock_settle", ST_SETTLE, 4'd1);
    expect_at(19, "t4_relock_ready",  ST_READY,  4'd1);
    tick(22);
`else
    expect_at(3, "t4_fault", ST_FAULT, 4'd0);
    tick(10);
    expect_at(0, "t4_fault_sticky", ST_FAULT, 4'd0);
`endif

    // Disable, then re-enable clears retries; disable again in WAIT_LOCK
    enable    = 1'b0;
    locked_in = 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    expect_at(1, "t5_disable_off", ST_OFF, 4'd1);
`else
    expect_at(1, "t5_disable_off", ST_OFF, 4'd0);
`endif
    tick(3);
    enable = 1'b1;
    expect_at(1, "t5_reenable_clear", ST_PWRUP, 4'd0);
    tick(13);
    expect_at(0, "t5_wait", ST_WAIT, 4'd0);
    tick(10);
    enable = 1'b0;
    expect_at(0, "t5_wait_before_off", ST_WAIT, 4'd0);
    expect_at(1, "t5_wait_to_off",     ST_OFF,  4'd0);
    tick(3);

    // Chatter on LOCKED: 10 high, 5 low, then steady
    enable = 1'b1;
    tick(13);
    expect_at(0, "t3_wait", ST_WAIT, 4'd0);
    tick(5);
    locked_in = 1'b1;
    tick(10);
    locked_in = 1'b0;
    expect_at(2, "t3_chatter_settle", ST_SETTLE, 4'd0);
    expect_at(3, "t3_chatter_back",   ST_WAIT,   4'd0);
    tick(5);
    locked_in = 1'b1;
    expect_at(18, "t3_pre_ready",  ST_SETTLE, 4'd0);
    expect_at(19, "t3_ready_rise", ST_READY,  4'd0);
    tick(22);

    // RST asserted during SETTLE
    enable    = 1'b0;
    locked_in = 1'b0;
    expect_at(1, "t5b_off", ST_OFF, 4'd0);
    tick(3);
    enable = 1'b1;
    tick(13);
    locked_in = 1'b1;
    expect_at(3, "t5b_settle", ST_SETTLE, 4'd0);
    tick(6);
    RST       = 1'b1;
    locked_in = 1'b0;
    expect_at(0, "t5b_settle_before_rst", ST_SETTLE, 4'd0);
    expect_at(1, "t5b_rst_to_off",        ST_OFF,    4'd0);
    tick(1);
    RST = 1'b0;

    // LOCKED stuck low: four reset attempts, then FAULT
    expect_at(1, "t2_pwrup", ST_PWRUP, 4'd0);
    for (int k = 0; k < 4; k++) begin
      int base;
      base = 13 + 108 * k;
      expect_at(base,      $sformatf("t2_wait_start_%0d", k), ST_WAIT, 4'(k));
      expect_at(base + 99, $sformatf("t2_wait_end_%0d", k),   ST_WAIT, 4'(k));
      if (k < 3) begin
        expect_at(base + 100, $sformatf("t2_retry_rst_%0d", k + 1),     ST_RSTH, 4'(k + 1));
        expect_at(base + 107, $sformatf("t2_retry_rst_end_%0d", k + 1), ST_RSTH, 4'(k + 1));
      end else begin
        expect_at(base + 100, "t2_fault", ST_FAULT, 4'd3);
      end
    end
    tick(13 + 108 * 3 + 100 + 5);
    expect_at(0, "t2_fault_sticky", ST_FAULT, 4'd3);

    // Lock arrives on the same cycle the timeout would fire
    enable = 1'b0;
    expect_at(1, "t6_off_keeps_retries", ST_OFF, 4'd3);
    tick(2);
    enable = 1'b1;
    expect_at(1, "t6_reenable_clear", ST_PWRUP, 4'd0);
    tick(13);
    expect_at(0, "t6_wait", ST_WAIT, 4'd0);
    tick(97);
    locked_in = 1'b1;
    expect_at(2, "t6_wait_last",       ST_WAIT,   4'd0);
    expect_at(3, "t6_lock_beats_tout", ST_SETTLE, 4'd0);
    tick(6);

    if (q_cyc.size() != 0) begin
      $display("FAIL pending_checks: %0d expectations never compared, want 0", q_cyc.size());
      n_bad += q_cyc.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
